// File: rtl/mem_arbiter_if.sv
// Bundle of the three requester ports and the AXI-bridge request/response channels.
// The arbiter connects through "master"; the requesters and the bridge connect through "slave".
interface mem_arbiter_if;
    logic        if_rvalid;
    logic [63:0] if_raddr;
    logic        if_rready;
    logic [63:0] if_rdata;
    logic [1:0]  if_resp;

    logic        d_rvalid;
    logic [63:0] d_raddr;
    logic [1:0]  d_rsize;
    logic        d_rready;
    logic [63:0] d_rdata;
    logic [1:0]  d_resp;

    logic        d_wvalid;
    logic [63:0] d_waddr;
    logic [63:0] d_wdata;
    logic [7:0]  d_wmask;
    logic        axi_w_isbusy;

    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic [63:0] bus_addr;
    logic [1:0]  bus_size;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;

    logic        bus_rsp_valid;
    logic [63:0] bus_rdata;
    logic [1:0]  bus_rsp;

    modport master (
        input  if_rvalid, if_raddr,
        output if_rready, if_rdata, if_resp,
        input  d_rvalid, d_raddr, d_rsize,
        output d_rready, d_rdata, d_resp,
        input  d_wvalid, d_waddr, d_wdata, d_wmask,
        output axi_w_isbusy,
        output bus_valid, bus_write, bus_addr, bus_size, bus_wdata, bus_wmask,
        input  bus_ready,
        input  bus_rsp_valid, bus_rdata, bus_rsp
    );

    modport slave (
        output if_rvalid, if_raddr,
        input  if_rready, if_rdata, if_resp,
        output d_rvalid, d_raddr, d_rsize,
        input  d_rready, d_rdata, d_resp,
        output d_wvalid, d_waddr, d_wdata, d_wmask,
        input  axi_w_isbusy,
        input  bus_valid, bus_write, bus_addr, bus_size, bus_wdata, bus_wmask,
        output bus_ready,
        output bus_rsp_valid, bus_rdata, bus_rsp
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter muxing instruction fetch, data read and data write onto one AXI bridge.
// Optional macro ARB_RR_EN: round-robin between fetch and the data group instead of DW > DR > IFR.
module mem_arbiter (
    input  logic          cpu_clk_50M,
    input  logic          cpu_rst_n,
    mem_arbiter_if.master arb
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {NONE, IFR, DR, DW} owner_t;

    state_t      r_state;
    state_t      w_state_nxt;
    owner_t      r_owner;
    owner_t      w_grant;

    logic [63:0] r_addr;
    logic [1:0]  r_size;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [63:0] r_rdata;
    logic [1:0]  r_rsp;

    logic        w_owner_vld;
    logic        w_latch;
    logic        w_capture;
    logic        w_issue;
    logic        w_done;

    // Grant selection, evaluated only while IDLE
`ifdef ARB_RR_EN
    logic r_last_data;
    logic w_data_req;

    assign w_data_req = arb.d_wvalid | arb.d_rvalid;

    always_comb begin
        w_grant = NONE;
        if (w_data_req && (!arb.if_rvalid || !r_last_data)) begin
            w_grant = arb.d_wvalid ? DW : DR;
        end else if (arb.if_rvalid) begin
            w_grant = IFR;
        end
    end

    // Reset value favours fetch on the first contended grant
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_last_data <= 1'b1;
        end else if (w_latch) begin
            r_last_data <= (w_grant != IFR);
        end
    end
`else
    always_comb begin
        w_grant = NONE;
        if (arb.d_wvalid) begin
            w_grant = DW;
        end else if (arb.d_rvalid) begin
            w_grant = DR;
        end else if (arb.if_rvalid) begin
            w_grant = IFR;
        end
    end
`endif

    always_comb begin
        case (r_owner)
            IFR:     w_owner_vld = arb.if_rvalid;
            DR:      w_owner_vld = arb.d_rvalid;
            DW:      w_owner_vld = arb.d_wvalid;
            default: w_owner_vld = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant != NONE) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // A flushed requester withdraws before the bridge has seen anything
                if (!w_owner_vld) begin
                    w_state_nxt = IDLE;
                end else if (arb.bus_ready) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (arb.bus_rsp_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_state <= IDLE;
            r_owner <= NONE;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) begin
                r_owner <= w_grant;
            end else if (w_state_nxt == IDLE) begin
                r_owner <= NONE;
            end
        end
    end

    // Request fields frozen at grant so the bus sees them stable through ISSUE
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_addr  <= '0;
            r_size  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_latch) begin
            case (w_grant)
                DW: begin
                    r_addr  <= arb.d_waddr;
                    r_size  <= 2'b11;
                    r_wdata <= arb.d_wdata;
                    r_wmask <= arb.d_wmask;
                end
                DR: begin
                    r_addr  <= arb.d_raddr;
                    r_size  <= arb.d_rsize;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
                default: begin
                    r_addr  <= arb.if_raddr;
                    r_size  <= 2'b11;
                    r_wdata <= '0;
                    r_wmask <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_rdata <= '0;
            r_rsp   <= '0;
        end else if (w_capture) begin
            r_rdata <= arb.bus_rdata;
            r_rsp   <= arb.bus_rsp;
        end
    end

    assign w_issue = (r_state == ISSUE);
    assign w_done  = (r_state == DONE);

    assign arb.bus_valid = w_issue && w_owner_vld;
    assign arb.bus_write = w_issue && (r_owner == DW);
    assign arb.bus_addr  = w_issue ? r_addr  : '0;
    assign arb.bus_size  = w_issue ? r_size  : '0;
    assign arb.bus_wdata = w_issue ? r_wdata : '0;
    assign arb.bus_wmask = w_issue ? r_wmask : '0;

    // Data returned to a requester that has since dropped valid is discarded
    assign arb.if_rready = w_done && (r_owner == IFR) && arb.if_rvalid;
    assign arb.d_rready  = w_done && (r_owner == DR)  && arb.d_rvalid;

    assign arb.if_rdata  = arb.if_rready ? r_rdata : '0;
    assign arb.if_resp   = arb.if_rready ? r_rsp   : '0;
    assign arb.d_rdata   = arb.d_rready  ? r_rdata : '0;
    assign arb.d_resp    = arb.d_rready  ? r_rsp   : '0;

    assign arb.axi_w_isbusy = (r_owner == DW) && (r_state != IDLE);

endmodule
